// File: rtl/fabric_pkg.sv
// Shared types and constants for the fabric memory-port arbiter.
package fabric_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_RESP
    } state_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    localparam int CLI_LOAD  = 0;
    localparam int CLI_STORE = 1;
    localparam int CLI_HOST  = 2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo NCLI.
module rr_pick #(
    parameter int NCLI = 3,
    parameter int IW   = $clog2(NCLI)
) (
    input  logic [NCLI-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NCLI-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Two passes: indices above ptr first, then wrap around from 0.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NCLI; i++) begin
            if (!any && req[i] && (IW'(i) > ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        for (int i = 0; i < NCLI; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/txn_arbiter.sv
// Shares the single edge-triggered memory transaction port among NCLI
// requesters using a level req/gnt/done handshake on the client side.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a request while memory is ready; grants here
// ST_ISSUE   | one-cycle txn_req strobe with latched fields
// ST_WAIT_LO | waiting for txn_rdy to fall; bounded by ACK_TIMEOUT
// ST_WAIT_HI | memory busy; waits unbounded for txn_rdy to rise
// ST_RESP    | cl_done (and cl_err on timeout) to the owning client
module txn_arbiter
    import fabric_pkg::*;
#(
    parameter int NCLI        = 3,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCLI-1:0]      cl_req,
    input  logic [NCLI-1:0]      cl_wr,
    input  logic [NCLI*AW-1:0]   cl_addr,
    input  logic [NCLI*DW-1:0]   cl_wdata,
    output logic [NCLI-1:0]      cl_gnt,
    output logic [NCLI-1:0]      cl_done,
    output logic [DW-1:0]        cl_rdata,
    output logic                 cl_err,
    output logic                 busy,
    output logic                 txn_req,
    output logic                 txn_wr,
    output logic [AW-1:0]        txn_waddr,
    output logic [AW-1:0]        txn_raddr,
    output logic [DW-1:0]        txn_wdata,
    input  logic [DW-1:0]        txn_rdata,
    input  logic                 txn_rdy
);

    localparam int IW = $clog2(NCLI);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t          state, state_nx;
    logic [IW-1:0]   ptr;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic [TW-1:0]   tmo_cnt;
    logic            err_q;

    logic [NCLI-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            grant_ok;
    logic            sel_wr;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    rr_pick #(.NCLI(NCLI), .IW(IW)) u_pick (
        .req (cl_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // rst also masks the combinational pulses so a reset cycle never grants or completes.
    assign grant_ok = (state == ST_IDLE) && txn_rdy && pick_any && !rst;

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCLI; i++) begin
            if (pick_gnt[i]) begin
                sel_wr    = cl_wr[i];
                sel_addr  = cl_addr[i*AW +: AW];
                sel_wdata = cl_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (grant_ok) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!txn_rdy)            state_nx = ST_WAIT_HI;
                else if (tmo_cnt == '0)  state_nx = ST_RESP;
            end
            ST_WAIT_HI: if (txn_rdy) state_nx = ST_RESP;
            ST_RESP:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= IW'(NCLI - 1);
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        ptr     <= pick_idx;
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                // Down-counter: ACK_TIMEOUT WAIT_LO cycles with txn_rdy high expire it.
                ST_ISSUE: tmo_cnt <= TW'(ACK_TIMEOUT - 1);
                ST_WAIT_LO: begin
                    if (txn_rdy) begin
                        if (tmo_cnt == '0) err_q   <= 1'b1;
                        else               tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                ST_WAIT_HI: if (txn_rdy && !wr_q) rdata_q <= txn_rdata;
                ST_RESP:    err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        cl_done = '0;
        for (int i = 0; i < NCLI; i++) begin
            cl_done[i] = (state == ST_RESP) && !rst && (ptr == IW'(i));
        end
    end

    assign cl_gnt    = grant_ok ? pick_gnt : '0;
    assign cl_err    = (state == ST_RESP) && !rst && err_q;
    assign txn_req   = (state == ST_ISSUE) && !rst;
    assign busy      = (state != ST_IDLE);
    assign txn_wr    = wr_q;
    assign txn_waddr = addr_q;
    assign txn_raddr = addr_q;
    assign txn_wdata = wdata_q;
    assign cl_rdata  = rdata_q;

endmodule

// File: tb/tb_txn_arbiter.sv
// Bench for txn_arbiter: timeline-based reference model with a memory responder,
// directed scenarios and a randomized multi-client phase.
module tb_txn_arbiter;
    import fabric_pkg::*;

    localparam int NCLI = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int T    = 8;
    localparam int BIG  = 1 << 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCLI-1:0]   cl_req;
    logic [NCLI-1:0]   cl_wr;
    logic [NCLI*AW-1:0] cl_addr;
    logic [NCLI*DW-1:0] cl_wdata;
    logic [NCLI-1:0]   cl_gnt;
    logic [NCLI-1:0]   cl_done;
    logic [DW-1:0]     cl_rdata;
    logic              cl_err;
    logic              busy;
    logic              txn_req;
    logic              txn_wr;
    logic [AW-1:0]     txn_waddr;
    logic [AW-1:0]     txn_raddr;
    logic [DW-1:0]     txn_wdata;
    logic [DW-1:0]     txn_rdata;
    logic              txn_rdy;

    always #5 clk = ~clk;

    txn_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .cl_req(cl_req), .cl_wr(cl_wr), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
        .cl_gnt(cl_gnt), .cl_done(cl_done), .cl_rdata(cl_rdata), .cl_err(cl_err),
        .busy(busy), .txn_req(txn_req), .txn_wr(txn_wr),
        .txn_waddr(txn_waddr), .txn_raddr(txn_raddr), .txn_wdata(txn_wdata),
        .txn_rdata(txn_rdata), .txn_rdy(txn_rdy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: rdy falls 2 cycles after the strobe, stays low mem_lat cycles.
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    int   mem_lat        = 16;
    bit   mem_ignore     = 1'b0;
    bit   mem_force_busy = 1'b0;
    bit   req_seen;
    logic [3:0]  m_idx;
    logic        m_wr;
    logic [31:0] m_data;
    int   m_phase = 0;
    int   m_cnt   = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h1111_1111 * i;
            ref_mem[i] = 32'h1111_1111 * i;
        end
        mem[2]     = 32'hDEAD_BEEF;
        ref_mem[2] = 32'hDEAD_BEEF;
        txn_rdy   = 1'b1;
        txn_rdata = '0;
        forever begin
            @(negedge clk);
            req_seen = txn_req;
            if (req_seen) begin
                m_idx  = txn_waddr[5:2];
                m_wr   = txn_wr;
                m_data = txn_wdata;
            end
            @(posedge clk); #1;
            if (req_seen && !mem_ignore) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                txn_rdy = 1'b0;
                m_cnt   = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 6));
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (m_wr) begin
                        mem[m_idx] = m_data;
                        txn_rdata  = $urandom;
                    end else begin
                        txn_rdata  = mem[m_idx];
                    end
                    txn_rdy = 1'b1;
                    m_phase = 0;
                end
            end else begin
                txn_rdy = !mem_force_busy;
            end
        end
    end

    function automatic int rr_model(input logic [NCLI-1:0] req, input int last_g);
        for (int d = 1; d <= NCLI; d++) begin
            if (req[(last_g + d) % NCLI]) return (last_g + d) % NCLI;
        end
        return -1;
    endfunction

    // Reference model: one outstanding transaction described by event timestamps.
    int   cyc = 0;
    bit   outst = 1'b0;
    int   owner, gcyc, lo_c, hi_c, dcyc;
    int   last_g = NCLI - 1;
    bit   o_wr;
    logic [31:0] o_addr, o_wdata;
    logic [31:0] exp_rdata = '0;
    bit   post_rst = 1'b0;
    bit   prev_req = 1'b0;

    always @(negedge clk) begin : cmp
        logic [NCLI-1:0] e_gnt, e_done;
        logic e_req, e_err, e_busy;
        bit   is_done;
        int   idx;
        cyc++;
        if (rst) begin
            chk("rst_gnt", cl_gnt, 0);
            chk("rst_done", cl_done, 0);
            chk("rst_req", txn_req, 0);
            outst     = 1'b0;
            last_g    = NCLI - 1;
            exp_rdata = '0;
            post_rst  = 1'b1;
        end else begin
            e_gnt = '0; e_done = '0; e_req = 1'b0; e_err = 1'b0; e_busy = 1'b0;
            is_done = 1'b0;
            if (post_rst) begin
                chk("post_rst_busy", busy, 0);
                chk("post_rst_req", txn_req, 0);
                chk("post_rst_wr", txn_wr, 0);
                chk("post_rst_waddr", txn_waddr, 0);
                chk("post_rst_raddr", txn_raddr, 0);
                chk("post_rst_wdata", txn_wdata, 0);
                chk("post_rst_done", {cl_done, cl_err}, 0);
                post_rst = 1'b0;
            end
            if (outst) begin
                e_busy = 1'b1;
                e_req  = (cyc == gcyc + 1);
                if (lo_c < 0 && cyc >= gcyc + 2 && cyc < gcyc + 2 + T && !txn_rdy) lo_c = cyc;
                else if (lo_c >= 0 && hi_c < 0 && cyc > lo_c && txn_rdy) hi_c = cyc;
                dcyc = (lo_c < 0) ? gcyc + 2 + T : ((hi_c >= 0) ? hi_c + 1 : BIG);
                if (cyc == dcyc) begin
                    is_done       = 1'b1;
                    e_done[owner] = 1'b1;
                    e_err         = (lo_c < 0);
                end
                if (cyc == gcyc + 1) begin
                    chk("issue_wr", txn_wr, o_wr);
                    chk("issue_raddr", txn_raddr, o_addr);
                    chk("issue_wdata", txn_wdata, o_wdata);
                end
                chk("addr_hold", txn_waddr, o_addr);
            end else if (txn_rdy && cl_req != '0) begin
                idx        = rr_model(cl_req, last_g);
                e_gnt[idx] = 1'b1;
                outst   = 1'b1;
                owner   = idx;
                gcyc    = cyc;
                lo_c    = -1;
                hi_c    = -1;
                last_g  = idx;
                o_wr    = cl_wr[idx];
                o_addr  = cl_addr[idx*AW +: AW];
                o_wdata = cl_wdata[idx*DW +: DW];
            end
            chk("gnt", cl_gnt, e_gnt);
            chk("txn_req", txn_req, e_req);
            chk("done", cl_done, e_done);
            chk("err", cl_err, e_err);
            chk("busy", busy, e_busy);
            if (is_done) begin
                if (lo_c >= 0 && !o_wr) exp_rdata = ref_mem[o_addr[5:2]];
                if (lo_c >= 0 && o_wr)  ref_mem[o_addr[5:2]] = o_wdata;
                outst = 1'b0;
            end
            chk("rdata", cl_rdata, exp_rdata);
        end
        chk("req_gap", prev_req & txn_req, 0);
        prev_req = txn_req;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_cli(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        cl_req[i]            = 1'b1;
        cl_wr[i]             = wr;
        cl_addr[i*AW +: AW]  = a;
        cl_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_gnt(input int i, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cl_gnt[i]) begin ok = 1'b1; break; end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_done(input int i, input string name, output int n,
                             output logic [31:0] rd, output logic er);
        bit ok = 1'b0;
        n = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n++;
            if (cl_done[i]) begin ok = 1'b1; rd = cl_rdata; er = cl_err; break; end
        end
        chk(name, ok, 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int n;
        logic [31:0] rd;
        logic er;
        bit ok;
        logic [NCLI-1:0] g;
        int got[$];
        int exp_ord[6];
        exp_ord = '{0, 1, 2, 0, 1, 2};

        rst = 1'b1; cl_req = '0; cl_wr = '0; cl_addr = '0; cl_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single read, 16-cycle memory: gnt g, issue g+1, rdy low g+3..g+18, done g+20.
        mem_lat = 16;
        set_cli(CLI_LOAD, 1'b0, 32'h4000_0008, 32'h0);
        wait_gnt(CLI_LOAD, "rd_gnt");
        @(negedge clk);
        chk("rd_issue_req", txn_req, 1);
        chk("rd_issue_raddr", txn_raddr, 32'h4000_0008);
        chk("rd_issue_wr", txn_wr, 0);
        tick(); cl_req[CLI_LOAD] = 1'b0;
        wait_done(CLI_LOAD, "rd_done", n, rd, er);
        chk("rd_latency", 1 + n, 20);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);

        // Single write, 3-cycle memory: done at g+7.
        mem_lat = 3;
        set_cli(CLI_STORE, 1'b1, 32'h4000_1004, 32'h1234_5678);
        wait_gnt(CLI_STORE, "wr_gnt");
        @(negedge clk);
        chk("wr_issue_wr", txn_wr, 1);
        chk("wr_issue_waddr", txn_waddr, 32'h4000_1004);
        chk("wr_issue_wdata", txn_wdata, 32'h1234_5678);
        tick(); cl_req[CLI_STORE] = 1'b0;
        wait_done(CLI_STORE, "wr_done", n, rd, er);
        chk("wr_latency", 1 + n, 7);
        chk("wr_rdata_kept", rd, 32'hDEAD_BEEF);
        chk("wr_mem", mem[1], 32'h1234_5678);

        // Timeout: memory never drops rdy, done+err at g+10.
        mem_ignore = 1'b1;
        set_cli(CLI_HOST, 1'b0, 32'h4000_0000, 32'h0);
        wait_gnt(CLI_HOST, "tmo_gnt");
        @(negedge clk);
        tick(); cl_req[CLI_HOST] = 1'b0;
        wait_done(CLI_HOST, "tmo_done", n, rd, er);
        chk("tmo_latency", 1 + n, 2 + T);
        chk("tmo_err", er, 1);
        @(negedge clk);
        chk("tmo_busy_clear", busy, 0);
        mem_ignore = 1'b0;
        tick();

        // Contention from reset: all clients request continuously.
        mem_lat = 2;
        rst = 1'b1;
        set_cli(0, 1'b0, 32'h4000_0008, 32'h0);
        set_cli(1, 1'b1, 32'h4000_0020, 32'hCAFE_0001);
        set_cli(2, 1'b0, 32'h4000_0004, 32'h0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 400 && got.size() < 6; k++) begin
            @(negedge clk);
            if (cl_gnt != '0) got.push_back($clog2(cl_gnt));
        end
        chk("rr_count", got.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < got.size()) chk("rr_order", got[k], exp_ord[k]);
        end
        tick(); cl_req = '0;
        repeat (30) tick();

        // Reset while the memory is busy with a read in WAIT_HI.
        mem_lat = 16;
        set_cli(1, 1'b0, 32'h4000_0010, 32'h0);
        wait_gnt(1, "mrst_gnt");
        tick(); cl_req[1] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!txn_rdy) begin ok = 1'b1; break; end
        end
        chk("mrst_rdy_low", ok, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", cl_done, 0);
        chk("mrst_rdata", cl_rdata, 0);
        chk("mrst_waddr", txn_waddr, 0);
        tick();
        set_cli(0, 1'b0, 32'h4000_0004, 32'h0);
        set_cli(1, 1'b0, 32'h4000_000C, 32'h0);
        ok = 1'b0; g = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cl_gnt != '0) begin ok = 1'b1; g = cl_gnt; break; end
        end
        chk("mrst_regrant_seen", ok, 1);
        chk("mrst_regrant_cli0", g, 3'b001);
        tick(); cl_req = '0;
        wait_done(0, "mrst_done2", n, rd, er);
        chk("mrst_rd_data", rd, 32'h1234_5678);
        chk("mrst_rd_err", er, 0);
        repeat (10) tick();

        // Memory busy while idle: no grant until rdy rises, then client 2 in that cycle.
        mem_lat = 2;
        @(negedge clk); mem_force_busy = 1'b1;
        tick();
        set_cli(2, 1'b0, 32'h4000_0008, 32'h0);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (cl_gnt != '0) ok = 1'b0;
        end
        chk("busy_mem_nogrant", ok, 1);
        mem_force_busy = 1'b0;
        @(negedge clk);
        chk("busy_mem_rdy", txn_rdy, 1);
        chk("busy_mem_gnt2", cl_gnt, 3'b100);
        tick(); cl_req[2] = 1'b0;
        wait_done(2, "busy_mem_done", n, rd, er);
        chk("busy_mem_data", rd, 32'hDEAD_BEEF);
        repeat (5) tick();

        // Randomized clients against a random-latency memory.
        mem_lat = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); g = cl_gnt;
            @(posedge clk); #1;
            for (int i = 0; i < NCLI; i++) begin
                if (cl_req[i] && g[i]) cl_req[i] = 1'b0;
                else if (cl_req[i] && $urandom_range(0, 49) == 0) cl_req[i] = 1'b0;
                else if (!cl_req[i] && $urandom_range(0, 3) == 0)
                    set_cli(i, 1'($urandom_range(0, 1)),
                            32'h4000_0000 | 32'($urandom_range(0, 15) << 2), $urandom);
            end
        end
        cl_req = '0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
